// File: rtl/control_pipeline_if.sv
// control_pipeline_if: D-stage control bundle in, E/M/W control, stall, forwarding selects and counters out
interface control_pipeline_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  valid_D;
    logic                  ctrl_register_file_WE_D;
    logic                  ctrl_srcB_D;
    logic                  ctrl_register_file_WA_D;
    logic                  ctrl_data_memory_WE_D;
    logic                  ctrl_result_D;
    logic [2:0]            ctrl_ALU_op_D;
    logic [REG_ADDR_W-1:0] rs1_D, rs2_D, rd_D;
    logic                  flush_E;
    logic                  stall_D;
    logic                  ctrl_register_file_WE_E;
    logic                  ctrl_srcB_E;
    logic                  ctrl_register_file_WA_E;
    logic                  ctrl_data_memory_WE_E;
    logic                  ctrl_result_E;
    logic [2:0]            ctrl_ALU_op_E;
    logic [REG_ADDR_W-1:0] rs1_E, rs2_E, rd_E;
    logic [1:0]            fwd_A_E, fwd_B_E;
    logic                  ctrl_data_memory_WE_M;
    logic                  ctrl_result_M;
    logic [REG_ADDR_W-1:0] rd_M;
    logic                  ctrl_register_file_WE_W;
    logic                  ctrl_result_W;
    logic [REG_ADDR_W-1:0] rd_W;
    logic [CNT_W-1:0]      retired_cnt, stall_cnt;

    modport slave (
        input  valid_D, ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D,
               ctrl_data_memory_WE_D, ctrl_result_D, ctrl_ALU_op_D, rs1_D, rs2_D, rd_D, flush_E,
        output stall_D, ctrl_register_file_WE_E, ctrl_srcB_E, ctrl_register_file_WA_E,
               ctrl_data_memory_WE_E, ctrl_result_E, ctrl_ALU_op_E, rs1_E, rs2_E, rd_E,
               fwd_A_E, fwd_B_E, ctrl_data_memory_WE_M, ctrl_result_M, rd_M,
               ctrl_register_file_WE_W, ctrl_result_W, rd_W, retired_cnt, stall_cnt
    );

    modport master (
        output valid_D, ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D,
               ctrl_data_memory_WE_D, ctrl_result_D, ctrl_ALU_op_D, rs1_D, rs2_D, rd_D, flush_E,
        input  stall_D, ctrl_register_file_WE_E, ctrl_srcB_E, ctrl_register_file_WA_E,
               ctrl_data_memory_WE_E, ctrl_result_E, ctrl_ALU_op_E, rs1_E, rs2_E, rd_E,
               fwd_A_E, fwd_B_E, ctrl_data_memory_WE_M, ctrl_result_M, rd_M,
               ctrl_register_file_WE_W, ctrl_result_W, rd_W, retired_cnt, stall_cnt
    );
endinterface

// File: rtl/control_pipeline.sv
// control_pipeline: E/M/W control registers, load-use stall and E-stage forwarding selects; CTRL_PIPE_PERF_EN builds perf counters
module control_pipeline #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic                clk,
    input logic                rst_n,
    control_pipeline_if.slave  bus
);
    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic                  srcb;
        logic                  rf_wa;
        logic                  dm_we;
        logic                  result;
        logic [2:0]            alu_op;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } e_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic                  dm_we;
        logic                  result;
        logic [REG_ADDR_W-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  rf_we;
        logic                  result;
        logic [REG_ADDR_W-1:0] rd;
    } w_stage_t;

    e_stage_t e_q, e_d;
    m_stage_t m_q;
    w_stage_t w_q;
    logic     stall, wr_m, wr_w;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        return (wr_m && m_q.rd == rs) ? 2'b10 : (wr_w && w_q.rd == rs) ? 2'b01 : 2'b00;
    endfunction

    // Load-use detection and the next E contents (a bubble on flush or stall)
    always_comb begin
        stall = e_q.valid & e_q.result & (e_q.rd != '0) &
                ((e_q.rd == bus.rs1_D) | (e_q.rd == bus.rs2_D)) & bus.valid_D;
        e_d   = (bus.flush_E | stall) ? '0 :
                {bus.valid_D, bus.ctrl_register_file_WE_D, bus.ctrl_srcB_D, bus.ctrl_register_file_WA_D,
                 bus.ctrl_data_memory_WE_D, bus.ctrl_result_D, bus.ctrl_ALU_op_D,
                 bus.rs1_D, bus.rs2_D, bus.rd_D};
        wr_m  = m_q.valid & m_q.rf_we & (m_q.rd != '0);
        wr_w  = w_q.valid & w_q.rf_we & (w_q.rd != '0);
    end

    // E, M and W advance every cycle; nothing stalls downstream of D
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= '{valid: e_q.valid, rf_we: e_q.rf_we, dm_we: e_q.dm_we, result: e_q.result, rd: e_q.rd};
            w_q <= '{valid: m_q.valid, rf_we: m_q.rf_we, result: m_q.result, rd: m_q.rd};
        end
    end

    // Stage outputs with write enables qualified by the stage valid bit
    always_comb begin
        bus.stall_D                 = stall;
        bus.ctrl_register_file_WE_E = e_q.valid & e_q.rf_we;
        bus.ctrl_srcB_E             = e_q.srcb;
        bus.ctrl_register_file_WA_E = e_q.rf_wa;
        bus.ctrl_data_memory_WE_E   = e_q.valid & e_q.dm_we;
        bus.ctrl_result_E           = e_q.result;
        bus.ctrl_ALU_op_E           = e_q.alu_op;
        bus.rs1_E                   = e_q.rs1;
        bus.rs2_E                   = e_q.rs2;
        bus.rd_E                    = e_q.rd;
        bus.fwd_A_E                 = fwd_sel(e_q.rs1);
        bus.fwd_B_E                 = fwd_sel(e_q.rs2);
        bus.ctrl_data_memory_WE_M   = m_q.valid & m_q.dm_we;
        bus.ctrl_result_M           = m_q.result;
        bus.rd_M                    = m_q.rd;
        bus.ctrl_register_file_WE_W = w_q.valid & w_q.rf_we;
        bus.ctrl_result_W           = w_q.result;
        bus.rd_W                    = w_q.rd;
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] retired_q, stall_q;

    // Free-running counters of retirements and load-use stalls, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_q + CNT_W'(w_q.valid);
            stall_q   <= stall_q + CNT_W'(stall);
        end
    end

    // Expose the counters
    always_comb begin
        bus.retired_cnt = retired_q;
        bus.stall_cnt   = stall_q;
    end
`else
    // Counters not built
    always_comb begin
        bus.retired_cnt = {CNT_W{1'b0}};
        bus.stall_cnt   = {CNT_W{1'b0}};
    end
`endif
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed stimulus with a cycle-tagged expectation queue drained by a monitor
module tb_control_pipeline;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fin = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef CTRL_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int S_STALL = 0, S_ALU_E = 1, S_RFWE_E = 2, S_DMWE_E = 3, S_RS2_E = 4, S_RD_E = 5,
                   S_FWDA = 6, S_FWDB = 7, S_DMWE_M = 8, S_RD_M = 9, S_RFWE_W = 10, S_RD_W = 11,
                   S_RET = 12, S_STC = 13;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    control_pipeline_if #(.REG_ADDR_W(5), .CNT_W(32)) bus();

    control_pipeline #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(input int s);
        case (s)
            S_STALL:  return 32'(bus.stall_D);
            S_ALU_E:  return 32'(bus.ctrl_ALU_op_E);
            S_RFWE_E: return 32'(bus.ctrl_register_file_WE_E);
            S_DMWE_E: return 32'(bus.ctrl_data_memory_WE_E);
            S_RS2_E:  return 32'(bus.rs2_E);
            S_RD_E:   return 32'(bus.rd_E);
            S_FWDA:   return 32'(bus.fwd_A_E);
            S_FWDB:   return 32'(bus.fwd_B_E);
            S_DMWE_M: return 32'(bus.ctrl_data_memory_WE_M);
            S_RD_M:   return 32'(bus.rd_M);
            S_RFWE_W: return 32'(bus.ctrl_register_file_WE_W);
            S_RD_W:   return 32'(bus.rd_W);
            S_RET:    return bus.retired_cnt;
            default:  return bus.stall_cnt;
        endcase
    endfunction

    function automatic string nm(input int s);
        case (s)
            S_STALL:  return "stall_D";
            S_ALU_E:  return "ctrl_ALU_op_E";
            S_RFWE_E: return "ctrl_register_file_WE_E";
            S_DMWE_E: return "ctrl_data_memory_WE_E";
            S_RS2_E:  return "rs2_E";
            S_RD_E:   return "rd_E";
            S_FWDA:   return "fwd_A_E";
            S_FWDB:   return "fwd_B_E";
            S_DMWE_M: return "ctrl_data_memory_WE_M";
            S_RD_M:   return "rd_M";
            S_RFWE_W: return "ctrl_register_file_WE_W";
            S_RD_W:   return "rd_W";
            S_RET:    return "retired_cnt";
            default:  return "stall_cnt";
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, mid-cycle away from the clock edge
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (obs(sb[i].sel) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (fin) begin
            foreach (sb[i]) begin
                checks++;
                errors++;
                $display("FAIL %s never checked (due cycle %0d)", nm(sb[i].sel), sb[i].cyc);
            end
            sb.delete();
        end
    end

    task automatic expect_at(input int dc, input int s, input logic [31:0] v);
        sb.push_back('{cyc + dc, s, v});
    endtask

    task automatic set_in(input logic v, rfwe, dmwe, res, input logic [2:0] alu,
                          input logic [4:0] rs1, rs2, rd, input logic fl);
        bus.valid_D                 = v;
        bus.ctrl_register_file_WE_D = rfwe;
        bus.ctrl_srcB_D             = res | dmwe;
        bus.ctrl_register_file_WA_D = rfwe;
        bus.ctrl_data_memory_WE_D   = dmwe;
        bus.ctrl_result_D           = res;
        bus.ctrl_ALU_op_D           = alu;
        bus.rs1_D                   = rs1;
        bus.rs2_D                   = rs2;
        bus.rd_D                    = rd;
        bus.flush_E                 = fl;
    endtask

    task automatic drv(input logic v, rfwe, dmwe, res, input logic [2:0] alu,
                       input logic [4:0] rs1, rs2, rd, input logic fl);
        @(posedge clk);
        #2;
        set_in(v, rfwe, dmwe, res, alu, rs1, rs2, rd, fl);
    endtask

    task automatic alu_i(input logic [2:0] alu, input logic [4:0] rs1, rs2, rd);
        drv(1'b1, 1'b1, 1'b0, 1'b0, alu, rs1, rs2, rd, 1'b0);
    endtask

    task automatic load(input logic [4:0] rs1, rd);
        drv(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, rs1, 5'd0, rd, 1'b0);
    endtask

    task automatic store(input logic [4:0] rs1, rs2, rd);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, rs1, rs2, rd, 1'b0);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        idle();
        expect_at(0, S_STALL, 0);
        expect_at(0, S_RFWE_W, 0);
        expect_at(0, S_DMWE_M, 0);
        expect_at(0, S_RD_E, 0);
        expect_at(0, S_RET, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // plain flow
        alu_i(3'b010, 5'd1, 5'd2, 5'd5);
        expect_at(1, S_ALU_E, 2);
        expect_at(1, S_RFWE_E, 1);
        expect_at(1, S_RD_E, 5);
        expect_at(2, S_RD_M, 5);
        expect_at(2, S_RFWE_W, 0);
        expect_at(3, S_RFWE_W, 1);
        expect_at(3, S_RD_W, 5);
        // load-use: one stall, one bubble, then W forwarding
        load(5'd1, 5'd7);
        expect_at(0, S_STALL, 0);
        alu_i(3'b000, 5'd2, 5'd7, 5'd8);
        expect_at(0, S_STALL, 1);
        expect_at(1, S_RD_E, 0);
        expect_at(1, S_RFWE_E, 0);
        alu_i(3'b000, 5'd2, 5'd7, 5'd8);
        expect_at(0, S_STALL, 0);
        expect_at(1, S_RD_E, 8);
        expect_at(1, S_RS2_E, 7);
        expect_at(1, S_FWDB, 1);
        expect_at(1, S_FWDA, 0);
        // forward priority M over W
        alu_i(3'b000, 5'd0, 5'd0, 5'd3);
        alu_i(3'b000, 5'd0, 5'd0, 5'd3);
        alu_i(3'b000, 5'd3, 5'd0, 5'd9);
        expect_at(1, S_FWDA, 2);
        expect_at(1, S_FWDB, 0);
        // M invalid -> W
        alu_i(3'b000, 5'd0, 5'd0, 5'd3);
        idle();
        alu_i(3'b000, 5'd3, 5'd0, 5'd9);
        expect_at(1, S_FWDA, 1);
        // x0 is never a forwarding source
        alu_i(3'b000, 5'd0, 5'd0, 5'd0);
        alu_i(3'b000, 5'd0, 5'd0, 5'd0);
        alu_i(3'b000, 5'd0, 5'd0, 5'd9);
        expect_at(1, S_FWDA, 0);
        expect_at(1, S_FWDB, 0);
        // stores are never forwarded from
        store(5'd1, 5'd2, 5'd4);
        expect_at(1, S_DMWE_E, 1);
        expect_at(2, S_DMWE_M, 1);
        alu_i(3'b000, 5'd4, 5'd4, 5'd9);
        expect_at(1, S_FWDA, 0);
        expect_at(1, S_FWDB, 0);
        // load into x0 is no hazard
        load(5'd1, 5'd0);
        alu_i(3'b000, 5'd0, 5'd0, 5'd10);
        expect_at(0, S_STALL, 0);
        // flush squashes a store
        drv(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1, 5'd2, 5'd0, 1'b1);
        expect_at(1, S_DMWE_E, 0);
        expect_at(2, S_DMWE_M, 0);
        // flush and stall together
        load(5'd1, 5'd9);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd9, 5'd0, 5'd11, 1'b1);
        expect_at(0, S_STALL, 1);
        expect_at(1, S_RD_E, 0);
        expect_at(1, S_RFWE_E, 0);
        alu_i(3'b000, 5'd1, 5'd2, 5'd12);
        expect_at(0, S_STALL, 0);
        expect_at(1, S_RD_E, 12);
        // reset mid-stream
        alu_i(3'b000, 5'd0, 5'd0, 5'd13);
        store(5'd0, 5'd0, 5'd0);
        alu_i(3'b000, 5'd0, 5'd0, 5'd15);
        alu_i(3'b000, 5'd0, 5'd0, 5'd16);
        rst_n = 1'b0;
        expect_at(0, S_RFWE_W, 0);
        expect_at(0, S_DMWE_M, 0);
        expect_at(0, S_RFWE_E, 0);
        expect_at(0, S_RD_E, 0);
        expect_at(0, S_RD_W, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        // perf: 10 instructions, 2 load-use stalls
        alu_i(3'b000, 5'd0, 5'd0, 5'd1);
        expect_at(2, S_RFWE_W, 0);
        expect_at(3, S_RFWE_W, 1);
        expect_at(3, S_RD_W, 1);
        expect_at(4, S_RET, PERF ? 1 : 0);
        load(5'd1, 5'd11);
        alu_i(3'b000, 5'd11, 5'd0, 5'd12);
        expect_at(0, S_STALL, 1);
        alu_i(3'b000, 5'd11, 5'd0, 5'd12);
        expect_at(0, S_STALL, 0);
        expect_at(0, S_STC, PERF ? 1 : 0);
        alu_i(3'b000, 5'd0, 5'd0, 5'd13);
        load(5'd0, 5'd14);
        alu_i(3'b000, 5'd0, 5'd14, 5'd15);
        expect_at(0, S_STALL, 1);
        alu_i(3'b000, 5'd0, 5'd14, 5'd15);
        expect_at(0, S_STALL, 0);
        expect_at(1, S_FWDB, 1);
        for (int i = 0; i < 4; i++) alu_i(3'b001, 5'd0, 5'd0, 5'(16 + i));
        idle();
        expect_at(4, S_RET, PERF ? 10 : 0);
        expect_at(4, S_STC, PERF ? 2 : 0);
        repeat (6) idle();
        fin = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
